// File: rtl/fp_div_pkg.sv
// Shared FP32 constants and dispatch-state encoding for the FP32 divider front end.
package fp_div_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int FP_W   = 1 + EXP_W + FRAC_W;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } disp_state_e;

endpackage

// File: rtl/fp_div_opq.sv
// In-order operand queue: synchronous FIFO holding {a, b, tag} entries.
module fp_div_opq #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 68
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (count_r == (PTR_W + 1)'(DEPTH));
   assign empty  = (count_r == (PTR_W + 1)'(0));
   assign push_s = push && !full;
   assign pop_s  = pop && !empty;
   assign dout   = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
            2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

endmodule

// File: rtl/fp_div_dispatch.sv
// Issue stage for the iterative FP32 divider: queue, single-flight FSM, result slot.
// Optional counters enabled by defining FP_DIV_DISPATCH_STATS_EN.
module fp_div_dispatch
   import fp_div_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             div_valid_in,
   input  logic             div_ready,
   output logic [31:0]      div_a,
   output logic [31:0]      div_b,
   input  logic             div_valid_out,
   input  logic [31:0]      div_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag
`ifdef FP_DIV_DISPATCH_STATS_EN
   ,
   output logic [15:0]      stat_done,
   output logic [15:0]      stat_full_cycles
`endif
);

   localparam int ENT_W = 2 * FP_W + TAG_W;

   disp_state_e      state_r;
   disp_state_e      state_nxt_s;
   logic             q_full_s;
   logic             q_empty_s;
   logic             push_s;
   logic             pop_s;
   logic             capture_s;
   logic [ENT_W-1:0] q_din_s;
   logic [ENT_W-1:0] q_dout_s;
   logic             div_valid_in_r;
   logic [31:0]      div_a_r;
   logic [31:0]      div_b_r;
   logic [TAG_W-1:0] tag_hold_r;
   logic             in_flight_r;
   logic             out_valid_r;
   logic [31:0]      out_result_r;
   logic [TAG_W-1:0] out_tag_r;

   assign in_ready     = !q_full_s;
   assign push_s       = in_valid && !q_full_s;
   assign q_din_s      = {in_a, in_b, in_tag};
   assign div_valid_in = div_valid_in_r;
   assign div_a        = div_a_r;
   assign div_b        = div_b_r;
   assign out_valid    = out_valid_r;
   assign out_result   = out_result_r;
   assign out_tag      = out_tag_r;

   fp_div_opq #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_opq (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (q_din_s),
      .dout  (q_dout_s),
      .full  (q_full_s),
      .empty (q_empty_s)
   );

   // Next-state logic; issue waits for a free result slot and a quiet result bus.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!q_empty_s && div_ready && !out_valid_r && !div_valid_out) begin
               state_nxt_s = S_ISSUE;
               pop_s       = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ISSUE: state_nxt_s = S_WAIT;
         S_WAIT: begin
            if (div_valid_out && in_flight_r) begin
               state_nxt_s = S_IDLE;
               capture_s   = 1'b1;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register plus operand hold; operands stay put until the next pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         div_valid_in_r <= 1'b0;
         div_a_r        <= 32'h0000_0000;
         div_b_r        <= 32'h0000_0000;
         tag_hold_r     <= '0;
         in_flight_r    <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         div_valid_in_r <= pop_s;
         if (pop_s) begin
            {div_a_r, div_b_r, tag_hold_r} <= q_dout_s;
         end
         if (state_r == S_ISSUE) begin
            in_flight_r <= 1'b1;
         end else if (capture_s) begin
            in_flight_r <= 1'b0;
         end
      end
   end

   // Result slot: filled by the divider pulse, drained by the consumer handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r  <= 1'b0;
         out_result_r <= 32'h0000_0000;
         out_tag_r    <= '0;
      end else if (capture_s) begin
         out_valid_r  <= 1'b1;
         out_result_r <= div_result;
         out_tag_r    <= tag_hold_r;
      end else if (out_valid_r && out_ready) begin
         out_valid_r  <= 1'b0;
      end
   end

`ifdef FP_DIV_DISPATCH_STATS_EN
   logic [15:0] stat_done_r;
   logic [15:0] stat_full_cycles_r;

   assign stat_done        = stat_done_r;
   assign stat_full_cycles = stat_full_cycles_r;

   // Saturating completion and back-pressure counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_done_r        <= 16'h0000;
         stat_full_cycles_r <= 16'h0000;
      end else begin
         if (capture_s && (stat_done_r != 16'hFFFF)) begin
            stat_done_r <= stat_done_r + 16'd1;
         end
         if (in_valid && q_full_s && (stat_full_cycles_r != 16'hFFFF)) begin
            stat_full_cycles_r <= stat_full_cycles_r + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fp_div_dispatch.sv
// Directed self-checking bench for fp_div_dispatch with a small iterative-divider model.
module tb_fp_div_dispatch;

   localparam int TAG_W = 4;
   localparam int LAT   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = 32'h0;
   logic [31:0]      in_b = 32'h0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             div_valid_in;
   logic             div_ready;
   logic [31:0]      div_a;
   logic [31:0]      div_b;
   logic             div_valid_out = 1'b0;
   logic [31:0]      div_result = 32'h0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
`ifdef FP_DIV_DISPATCH_STATS_EN
   logic [15:0]      stat_done;
   logic [15:0]      stat_full_cycles;
`endif

   int total = 0;
   int bad   = 0;
   int issue_cnt  = 0;
   int vin_cycles = 0;
   int drop_cnt   = 0;

   logic        hold_busy = 1'b0;
   logic        dv_busy = 1'b0;
   logic        dv_samp = 1'b0;
   logic        dv_done = 1'b0;
   int          dv_cnt  = 0;
   logic [31:0] dv_a = 32'h0;
   logic [31:0] dv_b = 32'h0;

   logic [31:0] fa [5] = '{32'h4100_0000, 32'h4110_0000, 32'h3F80_0000, 32'h4120_0000, 32'h40C0_0000};
   logic [31:0] fb [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4000_0000, 32'h4080_0000, 32'h4000_0000};
   logic [31:0] fr [4] = '{32'h4080_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4020_0000};

   fp_div_dispatch #(.DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_tag        (in_tag),
      .div_valid_in  (div_valid_in),
      .div_ready     (div_ready),
      .div_a         (div_a),
      .div_b         (div_b),
      .div_valid_out (div_valid_out),
      .div_result    (div_result),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_tag       (out_tag)
`ifdef FP_DIV_DISPATCH_STATS_EN
      ,
      .stat_done        (stat_done),
      .stat_full_cycles (stat_full_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Known quotients for the directed vectors.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
         {32'h3F80_0000, 32'h0000_0000}: return 32'h7F80_0000;
         {32'h0000_0000, 32'h0000_0000}: return 32'h7FC0_0000;
         {32'h4100_0000, 32'h4000_0000}: return 32'h4080_0000;
         {32'h4110_0000, 32'h4040_0000}: return 32'h4040_0000;
         {32'h3F80_0000, 32'h4000_0000}: return 32'h3F00_0000;
         {32'h4120_0000, 32'h4080_0000}: return 32'h4020_0000;
         default:                        return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign div_ready = !hold_busy && !dv_busy;

   // Divider model: samples a/b one cycle after the handshake, ready again in DONE but drops valid_in there.
   always @(posedge clk) begin
      if (rst) begin
         dv_busy <= 1'b0; dv_samp <= 1'b0; dv_done <= 1'b0; dv_cnt <= 0;
         div_valid_out <= 1'b0; div_result <= 32'h0;
      end else begin
         div_valid_out <= 1'b0;
         dv_done       <= 1'b0;
         if (div_valid_in) vin_cycles <= vin_cycles + 1;
         if (div_valid_in && div_ready) begin
            if (dv_done) drop_cnt <= drop_cnt + 1;
            else begin
               issue_cnt <= issue_cnt + 1;
               dv_busy <= 1'b1; dv_samp <= 1'b1; dv_cnt <= LAT;
            end
         end else if (dv_busy) begin
            if (dv_samp) begin
               dv_a <= div_a; dv_b <= div_b; dv_samp <= 1'b0;
            end
            if (dv_cnt == 1) begin
               dv_busy <= 1'b0; dv_done <= 1'b1;
               div_valid_out <= 1'b1; div_result <= ref_div(dv_a, dv_b);
            end else begin
               dv_cnt <= dv_cnt - 1;
            end
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop_out;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic wait_out(input logic [31:0] ea, input logic [31:0] eb, output bit ok, output bit stable);
      bit seen;
      seen = 1'b0; ok = 1'b0; stable = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (div_valid_in) seen = 1'b1;
         if (seen && (div_a !== ea || div_b !== eb)) stable = 1'b0;
         if (out_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (div_valid_in !== 1'b0) begin bad++; $display("FAIL reset_div_valid_in got=%b exp=0", div_valid_in); end
      total++; if (div_a !== 32'h0) begin bad++; $display("FAIL reset_div_a got=%h exp=0", div_a); end
      total++; if (div_b !== 32'h0) begin bad++; $display("FAIL reset_div_b got=%h exp=0", div_b); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
      total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      bit ok, st;
      int ib, vb;
      ib = issue_cnt; vb = vin_cycles;
      push(32'h40C0_0000, 32'h4000_0000, 4'd3);
      wait_out(32'h40C0_0000, 32'h4000_0000, ok, st);
      total++; if (!ok) begin bad++; $display("FAIL single_timeout got=no_result exp=result"); end
      total++; if (out_result !== 32'h4040_0000) begin bad++; $display("FAIL single_result got=%h exp=40400000", out_result); end
      total++; if (out_tag !== 4'd3) begin bad++; $display("FAIL single_tag got=%0d exp=3", out_tag); end
      total++; if (!st) begin bad++; $display("FAIL single_operand_stable got=changed exp=stable"); end
      total++; if (issue_cnt - ib !== 1) begin bad++; $display("FAIL single_issue_count got=%0d exp=1", issue_cnt - ib); end
      total++; if (vin_cycles - vb !== 1) begin bad++; $display("FAIL single_pulse_width got=%0d exp=1", vin_cycles - vb); end
      pop_out();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_special;
      bit ok, st;
      push(32'h3F80_0000, 32'h0000_0000, 4'd1);
      wait_out(32'h3F80_0000, 32'h0000_0000, ok, st);
      total++; if (!ok || out_result !== 32'h7F80_0000) begin bad++; $display("FAIL special_inf got=%h exp=7f800000", out_result); end
      total++; if (out_tag !== 4'd1) begin bad++; $display("FAIL special_inf_tag got=%0d exp=1", out_tag); end
      pop_out();
      push(32'h0000_0000, 32'h0000_0000, 4'd2);
      wait_out(32'h0000_0000, 32'h0000_0000, ok, st);
      total++; if (!ok || out_result !== 32'h7FC0_0000) begin bad++; $display("FAIL special_nan got=%h exp=7fc00000", out_result); end
      total++; if (out_tag !== 4'd2) begin bad++; $display("FAIL special_nan_tag got=%0d exp=2", out_tag); end
      pop_out();
   endtask

   task automatic test_fill;
      bit ok, st;
      int ib;
      ib = issue_cnt;
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_a = fa[i]; in_b = fb[i]; in_tag = TAG_W'(i);
         total++; if (in_ready !== 1'(i < 4)) begin bad++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, 1'(i < 4)); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (issue_cnt !== ib) begin bad++; $display("FAIL fill_no_issue_busy got=%0d exp=0", issue_cnt - ib); end
      hold_busy = 1'b0;
      for (int j = 0; j < 4; j++) begin
         wait_out(fa[j], fb[j], ok, st);
         total++; if (!ok || out_tag !== TAG_W'(j)) begin bad++; $display("FAIL fill_tag[%0d] got=%0d exp=%0d", j, out_tag, j); end
         total++; if (out_result !== fr[j]) begin bad++; $display("FAIL fill_result[%0d] got=%h exp=%h", j, out_result, fr[j]); end
         pop_out();
      end
      repeat (30) @(negedge clk);
      total++; if (out_valid !== 1'b0 || issue_cnt - ib !== 4) begin bad++; $display("FAIL fill_fifth_dropped got=%0d issues exp=4", issue_cnt - ib); end
   endtask

   task automatic test_stall;
      bit ok, st, held;
      int ib;
      ib = issue_cnt;
      out_ready = 1'b0;
      push(32'h40C0_0000, 32'h4000_0000, 4'd5);
      push(32'h4100_0000, 32'h4000_0000, 4'd6);
      wait_out(32'h40C0_0000, 32'h4000_0000, ok, st);
      total++; if (!ok || out_tag !== 4'd5) begin bad++; $display("FAIL stall_first_tag got=%0d exp=5", out_tag); end
      held = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_tag !== 4'd5) held = 1'b0;
      end
      total++; if (!held) begin bad++; $display("FAIL stall_hold got=changed exp=stable"); end
      total++; if (issue_cnt - ib !== 1) begin bad++; $display("FAIL stall_no_second_issue got=%0d exp=1", issue_cnt - ib); end
      pop_out();
      wait_out(32'h4100_0000, 32'h4000_0000, ok, st);
      total++; if (!ok || out_result !== 32'h4080_0000 || out_tag !== 4'd6) begin bad++; $display("FAIL stall_second got=%h/%0d exp=40800000/6", out_result, out_tag); end
      pop_out();
   endtask

   task automatic test_reset_mid;
      bit ok, st, seen;
      hold_busy = 1'b1;
      push(32'h40C0_0000, 32'h4000_0000, 4'd7);
      push(32'h4100_0000, 32'h4000_0000, 4'd8);
      push(32'h4110_0000, 32'h4040_0000, 4'd9);
      hold_busy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (div_valid_in) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL midrst_issue_timeout got=none exp=issue"); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      total++; if (div_valid_in !== 1'b0) begin bad++; $display("FAIL midrst_div_valid_in got=%b exp=0", div_valid_in); end
      rst = 1'b0;
      @(negedge clk);
      push(32'h40C0_0000, 32'h4000_0000, 4'd10);
      wait_out(32'h40C0_0000, 32'h4000_0000, ok, st);
      total++; if (!ok || out_result !== 32'h4040_0000 || out_tag !== 4'd10) begin bad++; $display("FAIL midrst_after got=%h/%0d exp=40400000/10", out_result, out_tag); end
      pop_out();
      repeat (30) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_queue_dropped got=%b exp=0", out_valid); end
   endtask

`ifdef FP_DIV_DISPATCH_STATS_EN
   task automatic test_stats;
      bit ok, st;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push(32'h40C0_0000, 32'h4000_0000, TAG_W'(k));
         wait_out(32'h40C0_0000, 32'h4000_0000, ok, st);
         pop_out();
      end
      hold_busy = 1'b1;
      in_valid = 1'b1;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      total++; if (stat_done !== 16'd3) begin bad++; $display("FAIL stats_done got=%0d exp=3", stat_done); end
      total++; if (stat_full_cycles !== 16'd2) begin bad++; $display("FAIL stats_full got=%0d exp=2", stat_full_cycles); end
      hold_busy = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_special();
      test_fill();
      test_stall();
      test_reset_mid();
`ifdef FP_DIV_DISPATCH_STATS_EN
      test_stats();
`endif
      total++; if (drop_cnt !== 0) begin bad++; $display("FAIL dropped_issue got=%0d exp=0", drop_cnt); end
      total++; if (vin_cycles !== issue_cnt) begin bad++; $display("FAIL pulse_vs_handshake got=%0d exp=%0d", vin_cycles, issue_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
